// File: rtl/wr_sram_match_engine_pkg.sv
// Shared definitions for the write-side SRAM matcher and the SRAM pool back end.
package wr_sram_match_engine_pkg;

    localparam int NUM_SRAM_DEF = 32;
    localparam int SRAM_W_DEF   = $clog2(NUM_SRAM_DEF);
    localparam int SPACE_W_DEF  = 11;
    localparam int AMOUNT_W_DEF = 9;
    localparam int LEN_W_DEF    = 6;
    localparam int TICK_W_DEF   = 8;

    // Index value meaning "no SRAM selected".
    localparam int NO_SRAM = NUM_SRAM_DEF;

    typedef enum logic [1:0] {
        POL_MAX_AMOUNT = 2'd0,
        POL_MAX_SPACE  = 2'd1,
        POL_FIRST_FIT  = 2'd2,
        POL_RESERVED   = 2'd3
    } policy_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_candidate_cmp.sv
// Combinational scoring of one SRAM candidate against the current best.
module sram_candidate_cmp
    import wr_sram_match_engine_pkg::*;
#(
    parameter int NUM_SRAM = NUM_SRAM_DEF,
    parameter int SRAM_W   = $clog2(NUM_SRAM),
    parameter int SPACE_W  = SPACE_W_DEF,
    parameter int AMOUNT_W = AMOUNT_W_DEF,
    parameter int LEN_W    = LEN_W_DEF,
    parameter int SCORE_W  = max_int(SPACE_W, AMOUNT_W)
) (
    input  logic [1:0]          policy_q,
    input  logic [LEN_W-1:0]    len_q,
    input  logic [SRAM_W-1:0]   match_sram,
    input  logic                accessible,
    input  logic [SPACE_W-1:0]  free_space,
    input  logic [AMOUNT_W-1:0] packet_amount,
    input  logic                find,
    input  logic [SCORE_W-1:0]  best_score,
    output logic                eligible,
    output logic [SCORE_W-1:0]  score,
    output logic                better
);

    policy_t pol;
    logic    in_range;
    logic    space_ok;

    // Eligibility, policy score and ranking against the held best.
    always_comb begin
        pol      = policy_t'(policy_q);
        in_range = ({1'b0, match_sram} < (SRAM_W+1)'(NUM_SRAM));
        // One extra bit so new_length+1 cannot wrap.
        space_ok = ({1'b0, free_space} >= ((SPACE_W+1)'(len_q) + (SPACE_W+1)'(1)));
        eligible = accessible && in_range && space_ok;
        score    = (pol == POL_MAX_SPACE) ? SCORE_W'(free_space) : SCORE_W'(packet_amount);
        // First fit never replaces; scored policies replace only on strictly greater.
        better   = !find || ((pol != POL_FIRST_FIT) && (score > best_score));
    end

endmodule

// File: rtl/wr_sram_match_engine.sv
// Per-port write-side SRAM matcher: scans round-robin candidates, commits the best.
module wr_sram_match_engine
    import wr_sram_match_engine_pkg::*;
#(
    parameter int NUM_SRAM = NUM_SRAM_DEF,
    parameter int SRAM_W   = $clog2(NUM_SRAM),
    parameter int SPACE_W  = SPACE_W_DEF,
    parameter int AMOUNT_W = AMOUNT_W_DEF,
    parameter int LEN_W    = LEN_W_DEF,
    parameter int TICK_W   = TICK_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [TICK_W-1:0]   match_threshold,
    input  logic [TICK_W-1:0]   match_timeout,
    input  logic [1:0]          policy,
    input  logic [LEN_W-1:0]    new_length,
    input  logic                match_enable,
    input  logic                xfer_ready,
    input  logic [SRAM_W-1:0]   match_sram,
    input  logic                accessible,
    input  logic [SPACE_W-1:0]  free_space,
    input  logic [AMOUNT_W-1:0] packet_amount,
    output logic                match_busy,
    output logic                match_suc,
    output logic                match_fail,
    output logic [SRAM_W:0]     match_best_sram
);

    localparam int              SCORE_W = max_int(SPACE_W, AMOUNT_W);
    localparam logic [SRAM_W:0] NONE    = (SRAM_W+1)'(NUM_SRAM);

    state_t               state, state_d;
    logic [TICK_W-1:0]    tick;
    logic                 find;
    logic [SCORE_W-1:0]   best_score;
    logic [SRAM_W:0]      best_sram;
    logic [1:0]           pol_q;
    logic [LEN_W-1:0]     len_q;
    logic                 suc_q, fail_q;

    logic                 start, abort, scan_eval, take, commit, timeout_hit, rel_hit;
    logic                 cand_eligible, cand_better;
    logic [SCORE_W-1:0]   cand_score;

    sram_candidate_cmp #(
        .NUM_SRAM (NUM_SRAM),
        .SRAM_W   (SRAM_W),
        .SPACE_W  (SPACE_W),
        .AMOUNT_W (AMOUNT_W),
        .LEN_W    (LEN_W),
        .SCORE_W  (SCORE_W)
    ) u_cmp (
        .policy_q      (pol_q),
        .len_q         (len_q),
        .match_sram    (match_sram),
        .accessible    (accessible),
        .free_space    (free_space),
        .packet_amount (packet_amount),
        .find          (find),
        .best_score    (best_score),
        .eligible      (cand_eligible),
        .score         (cand_score),
        .better        (cand_better)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    // Next-state and per-cycle control decisions.
    always_comb begin
        state_d     = state;
        start       = 1'b0;
        abort       = 1'b0;
        scan_eval   = 1'b0;
        take        = 1'b0;
        commit      = 1'b0;
        timeout_hit = 1'b0;
        rel_hit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (match_enable) begin
                    start   = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!match_enable) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    scan_eval = 1'b1;
                    take      = cand_eligible && cand_better;
                    // A candidate taken this cycle counts toward the commit.
                    if ((tick >= match_threshold) && (find || take)) begin
                        commit  = 1'b1;
                        state_d = ST_HOLD;
                    end else if (tick == match_timeout) begin
                        timeout_hit = 1'b1;
                        state_d     = ST_FAIL;
                    end
                end
            end
            ST_HOLD: begin
                if (xfer_ready) begin
                    rel_hit = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan datapath: tick, best candidate, latched request and result pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick       <= '0;
            find       <= 1'b0;
            best_score <= '0;
            best_sram  <= NONE;
            pol_q      <= '0;
            len_q      <= '0;
            suc_q      <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            suc_q  <= commit;
            fail_q <= timeout_hit;
            if (start) begin
                tick       <= '0;
                find       <= 1'b0;
                best_score <= '0;
                best_sram  <= NONE;
                pol_q      <= policy;
                len_q      <= new_length;
            end
            if (scan_eval) begin
                if (tick != '1) tick <= tick + TICK_W'(1);
                if (take) begin
                    find       <= 1'b1;
                    best_score <= cand_score;
                    best_sram  <= {1'b0, match_sram};
                end
            end
            if (abort || timeout_hit || rel_hit) begin
                find      <= 1'b0;
                best_sram <= NONE;
            end
        end
    end

    // Status outputs.
    always_comb begin
        match_busy      = (state == ST_SCAN) || (state == ST_HOLD);
        match_suc       = suc_q;
        match_fail      = fail_q;
        match_best_sram = best_sram;
    end

endmodule

// File: tb/tb_wr_sram_match_engine.sv
// Self-checking bench for wr_sram_match_engine: vector table plus corner sequences.
module tb_wr_sram_match_engine;

    logic        clk;
    logic        rst_n;
    logic [7:0]  match_threshold;
    logic [7:0]  match_timeout;
    logic [1:0]  policy;
    logic [5:0]  new_length;
    logic        match_enable;
    logic        xfer_ready;
    logic [4:0]  match_sram;
    logic        accessible;
    logic [10:0] free_space;
    logic [8:0]  packet_amount;
    logic        match_busy;
    logic        match_suc;
    logic        match_fail;
    logic [5:0]  match_best_sram;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0]       pol;
        logic [7:0]       thr;
        logic [7:0]       to;
        logic [5:0]       len;
        logic [7:0]       acc;
        logic [7:0][10:0] free;
        logic [7:0][8:0]  amt;
        logic             exp_suc;
        logic [5:0]       exp_best;
        logic [7:0]       exp_lat;
    } vec_t;

    typedef struct {
        logic       suc;
        logic [5:0] best;
        int         lat;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    wr_sram_match_engine #(
        .NUM_SRAM (32),
        .SPACE_W  (11),
        .AMOUNT_W (9),
        .LEN_W    (6),
        .TICK_W   (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .match_threshold (match_threshold),
        .match_timeout   (match_timeout),
        .policy          (policy),
        .new_length      (new_length),
        .match_enable    (match_enable),
        .xfer_ready      (xfer_ready),
        .match_sram      (match_sram),
        .accessible      (accessible),
        .free_space      (free_space),
        .packet_amount   (packet_amount),
        .match_busy      (match_busy),
        .match_suc       (match_suc),
        .match_fail      (match_fail),
        .match_best_sram (match_best_sram)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] pol, input int thr, input int to, input int len,
                                input logic [7:0] acc, input logic s, input int best, input int lat);
        vec_t v;
        v.pol = pol; v.thr = 8'(thr); v.to = 8'(to); v.len = 6'(len); v.acc = acc;
        for (int i = 0; i < 8; i++) begin
            v.free[i] = 11'd100;
            v.amt[i]  = 9'd0;
        end
        v.exp_suc = s; v.exp_best = 6'(best); v.exp_lat = 8'(lat);
        return v;
    endfunction

    // mode 0: hold 'hold' cycles then release; mode 1: reset while in HOLD.
    task automatic run_vec(input string tag, input vec_t v, input int hold, input int mode);
        exp_t e;
        int   lat;
        bit   seen;
        lat  = 0;
        seen = 1'b0;
        @(negedge clk);
        policy = v.pol; match_threshold = v.thr; match_timeout = v.to; new_length = v.len;
        match_enable = 1'b1; xfer_ready = 1'b0; accessible = 1'b0;
        sb.push_back('{v.exp_suc, v.exp_best, int'(v.exp_lat)});
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) check({tag, "_busy_scan"}, match_busy, 1);
            if (match_suc || match_fail) begin
                seen = 1'b1;
                lat  = i - 1;
            end else begin
                match_sram    = 5'(i - 1);
                accessible    = (i - 1 < 8) ? v.acc[i-1] : 1'b0;
                free_space    = (i - 1 < 8) ? v.free[i-1] : 11'd0;
                packet_amount = (i - 1 < 8) ? v.amt[i-1] : 9'd0;
            end
        end
        e = sb.pop_front();
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_no_pulse: got none expected pulse within 40 cycles", tag);
            match_enable = 1'b0;
            @(negedge clk); xfer_ready = 1'b1;
            @(negedge clk); xfer_ready = 1'b0;
            return;
        end
        check({tag, "_suc"}, match_suc, e.suc);
        check({tag, "_fail"}, match_fail, !e.suc);
        check({tag, "_best"}, match_best_sram, e.best);
        check({tag, "_latency"}, lat, e.lat);
        if (!match_suc) begin
            match_enable = 1'b0;
            check({tag, "_busy_fail"}, match_busy, 0);
            @(negedge clk);
            check({tag, "_fail_width"}, match_fail, 0);
            check({tag, "_idle_best"}, match_best_sram, 32);
            return;
        end
        check({tag, "_busy_hold"}, match_busy, 1);
        if (mode == 1) begin
            rst_n = 1'b0;
            @(negedge clk);
            check({tag, "_rst_suc"}, match_suc, 0);
            check({tag, "_rst_fail"}, match_fail, 0);
            check({tag, "_rst_busy"}, match_busy, 0);
            check({tag, "_rst_best"}, match_best_sram, 32);
            rst_n = 1'b1; match_enable = 1'b0;
            @(negedge clk);
            check({tag, "_post_rst_busy"}, match_busy, 0);
            return;
        end
        for (int h = 0; h < hold; h++) begin
            match_enable  = 1'($urandom_range(0, 1));
            match_sram    = 5'($urandom_range(0, 31));
            accessible    = 1'b1;
            free_space    = 11'd2047;
            packet_amount = 9'd511;
            @(negedge clk);
            check({tag, "_hold_suc"}, match_suc, 0);
            check({tag, "_hold_best"}, match_best_sram, e.best);
            check({tag, "_hold_busy"}, match_busy, 1);
        end
        match_enable = 1'b0;
        xfer_ready   = 1'b1;
        @(negedge clk);
        xfer_ready = 1'b0;
        check({tag, "_rel_best"}, match_best_sram, 32);
        check({tag, "_rel_busy"}, match_busy, 0);
    endtask

    initial begin
        vec_t v;
        int   pulses;
        rst_n = 1'b0; match_threshold = '0; match_timeout = '0; policy = '0; new_length = '0;
        match_enable = 1'b0; xfer_ready = 1'b0; match_sram = '0; accessible = 1'b0;
        free_space = '0; packet_amount = '0;

        // Table: MAX_AMOUNT with and without idx4, MAX_SPACE, FIRST_FIT, timeout, boundaries.
        v = mk(2'd0, 4, 20, 10, 8'b0001_1111, 1, 4, 5);
        v.amt[0] = 3; v.amt[1] = 7; v.amt[2] = 7; v.amt[3] = 2; v.amt[4] = 9;
        vecs[0] = v;
        v.acc = 8'b0000_1111; v.exp_best = 6'd1; vecs[1] = v;
        v = mk(2'd1, 3, 20, 20, 8'b0000_1111, 1, 3, 4);
        v.free[0] = 20; v.free[1] = 21; v.free[2] = 50; v.free[3] = 300;
        vecs[2] = v;
        v = mk(2'd2, 0, 20, 5, 8'b1100_0000, 1, 6, 7);
        v.free[6] = 10; v.free[7] = 200;
        vecs[3] = v;
        v = mk(2'd2, 4, 20, 5, 8'b0000_0110, 1, 1, 5);
        v.free[1] = 10; v.free[2] = 200; v.amt[1] = 1; v.amt[2] = 50;
        vecs[4] = v;
        vecs[5] = mk(2'd0, 4, 8, 10, 8'b0000_0000, 0, 32, 9);
        v = mk(2'd0, 2, 20, 63, 8'b0000_0011, 1, 1, 3);
        v.free[0] = 63; v.amt[0] = 9; v.free[1] = 64; v.amt[1] = 1;
        vecs[6] = v;
        v = mk(2'd3, 2, 20, 10, 8'b0000_0111, 1, 1, 3);
        v.free[0] = 500; v.free[1] = 20; v.free[2] = 100;
        v.amt[0] = 1; v.amt[1] = 5; v.amt[2] = 2;
        vecs[7] = v;
        v = mk(2'd1, 3, 3, 10, 8'b0000_1000, 1, 3, 4);
        v.free[3] = 50;
        vecs[8] = v;
        v = mk(2'd0, 0, 20, 1, 8'b0000_0001, 1, 0, 1);
        v.free[0] = 2;
        vecs[9] = v;

        repeat (3) @(negedge clk);
        check("reset_suc", match_suc, 0);
        check("reset_fail", match_fail, 0);
        check("reset_busy", match_busy, 0);
        check("reset_best", match_best_sram, 32);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_vec($sformatf("vec%0d", i), vecs[i], (i == 0) ? 10 : 2, 0);

        // Abort mid-scan: no pulse, result cleared, xfer_ready in IDLE ignored.
        @(negedge clk);
        policy = 2'd0; match_threshold = 8'd10; match_timeout = 8'd50; new_length = 6'd1;
        match_enable = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            match_sram = 5'(i); accessible = 1'b1; free_space = 11'd100; packet_amount = 9'(i + 1);
        end
        @(negedge clk);
        match_enable = 1'b0;
        @(negedge clk);
        check("abort_busy", match_busy, 0);
        check("abort_best", match_best_sram, 32);
        xfer_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (match_suc || match_fail || match_busy) pulses++;
        end
        xfer_ready = 1'b0;
        check("abort_no_activity", pulses, 0);

        // Reset during HOLD.
        run_vec("rst_hold", vecs[9], 0, 1);
        // Normal restart after reset.
        run_vec("restart", vecs[2], 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
